// File: rtl/monitoramento_pressao_histerese_pkg.sv
// Shared types for the pressure hysteresis monitor: FSM state enum and alert codes.
package monitoramento_pkg;

   localparam logic [1:0] ALERTA_NORMAL = 2'b00;
   localparam logic [1:0] ALERTA_BAIXO  = 2'b01;
   localparam logic [1:0] ALERTA_ALTO   = 2'b10;

   // State encoding equals the alert code so alerta is the state register itself.
   typedef enum logic [1:0] {
      NORMAL = ALERTA_NORMAL,
      BAIXO  = ALERTA_BAIXO,
      ALTO   = ALERTA_ALTO
   } estado_t;

endpackage

// File: rtl/monitoramento_pressao_histerese_contador_confirmacao.sv
// Confirmation streak tracker: remembers the candidate class and counts
// consecutive valid samples agreeing with it. confirmado is combinational so
// the FSM changes state on the same edge that registers the final sample.
module contador_confirmacao
   import monitoramento_pkg::*;
#(
   parameter int CONFIRMA = 3
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    amostra_valida,
   input  estado_t estado,
   input  estado_t alvo,
   output logic    confirmado
);

   localparam int W = $clog2(CONFIRMA + 1);
   localparam logic [W:0] ALVO_CNT = (W + 1)'(CONFIRMA);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W:0]   cnt_mais;
   estado_t      cand_q, cand_d;

   // Next candidate/count; a confirmed change clears both so the new state starts fresh.
   always_comb begin
      cnt_d      = cnt_q;
      cand_d     = cand_q;
      confirmado = 1'b0;
      cnt_mais   = {1'b0, cnt_q} + (W + 1)'(1);
      if (amostra_valida) begin
         if (alvo == estado) begin
            cnt_d = '0;
         end else if (alvo == cand_q) begin
            // Reaching CONFIRMA always confirms and clears, which also bounds the count.
            if (cnt_mais >= ALVO_CNT) confirmado = 1'b1;
            else                      cnt_d = cnt_mais[W-1:0];
         end else begin
            cand_d = alvo;
            if (CONFIRMA == 1) confirmado = 1'b1;
            else               cnt_d = W'(1);
         end
         if (confirmado) begin
            cnt_d  = '0;
            cand_d = NORMAL;
         end
      end
   end

   // Streak registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         cand_q <= NORMAL;
      end else begin
         cnt_q  <= cnt_d;
         cand_q <= cand_d;
      end
   end

endmodule

// File: rtl/monitoramento_pressao_histerese.sv
// Pressure monitor with hysteresis, confirmation streak and sticky alarm.
// Optional build macro MONITORAMENTO_CONTADOR_EVENTOS_EN adds the 16-bit
// saturating 'eventos' counter of alarm entries.
//
// state  | meaning
// NORMAL | pressure within limits, alerta=00
// BAIXO  | confirmed low pressure, alerta=01
// ALTO   | confirmed high pressure, alerta=10
module monitoramento_pressao_histerese
   import monitoramento_pkg::*;
#(
   parameter int           N            = 8,
   parameter logic [N-1:0] LIMITE_BAIXO = N'(50),
   parameter logic [N-1:0] LIMITE_ALTO  = N'(150),
   parameter logic [N-1:0] HISTERESE    = N'(5),
   parameter int           CONFIRMA     = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         amostra_valida,
   input  logic [N-1:0] pressao,
   input  logic         reconhece,
   output logic [1:0]   alerta,
   output logic         alarme_travado
`ifdef MONITORAMENTO_CONTADOR_EVENTOS_EN
   ,
   output logic [15:0]  eventos
`endif
);

   localparam logic [N-1:0] SAIDA_BAIXO = LIMITE_BAIXO + HISTERESE;
   localparam logic [N-1:0] SAIDA_ALTO  = LIMITE_ALTO - HISTERESE;

   // Reject threshold sets whose hysteresis bands would wrap or overlap.
   if (CONFIRMA < 1 ||
       int'(HISTERESE) > int'(LIMITE_ALTO) ||
       int'(LIMITE_BAIXO) + int'(HISTERESE) > (2 ** N) - 1 ||
       int'(LIMITE_BAIXO) + int'(HISTERESE) > int'(LIMITE_ALTO) - int'(HISTERESE)) begin : g_param_erro
      $error("monitoramento_pressao_histerese: invalid thresholds/hysteresis/CONFIRMA");
   end

   estado_t estado_q, estado_d, alvo;
   logic    confirmado, entrada;
   logic    travado_q, travado_d;

   contador_confirmacao #(.CONFIRMA(CONFIRMA)) u_confirma (
      .clk            (clk),
      .rst_n          (rst_n),
      .amostra_valida (amostra_valida),
      .estado         (estado_q),
      .alvo           (alvo),
      .confirmado     (confirmado)
   );

   // Target class for this sample; exit thresholds are widened by the hysteresis band.
   always_comb begin
      alvo = estado_q;
      unique case (estado_q)
         NORMAL: begin
            if (pressao >= LIMITE_ALTO)       alvo = ALTO;
            else if (pressao < LIMITE_BAIXO)  alvo = BAIXO;
            else                              alvo = NORMAL;
         end
         ALTO: begin
            if (pressao < LIMITE_BAIXO)       alvo = BAIXO;
            else if (pressao < SAIDA_ALTO)    alvo = NORMAL;
            else                              alvo = ALTO;
         end
         BAIXO: begin
            if (pressao >= LIMITE_ALTO)       alvo = ALTO;
            else if (pressao >= SAIDA_BAIXO)  alvo = NORMAL;
            else                              alvo = BAIXO;
         end
         default: alvo = NORMAL;
      endcase
   end

   // Next state and sticky flag; a new alarm entry beats a simultaneous acknowledge.
   always_comb begin
      estado_d  = estado_q;
      travado_d = travado_q;
      entrada   = 1'b0;
      if (confirmado) begin
         estado_d = alvo;
         entrada  = (alvo != NORMAL);
      end
      if (reconhece && estado_q == NORMAL) travado_d = 1'b0;
      if (entrada)                         travado_d = 1'b1;
   end

   // State and latch registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q  <= NORMAL;
         travado_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         travado_q <= travado_d;
      end
   end

   assign alerta         = estado_q;
   assign alarme_travado = travado_q;

`ifdef MONITORAMENTO_CONTADOR_EVENTOS_EN
   logic [15:0] eventos_q, eventos_d;

   // Saturating count of alarm entries; acknowledge does not touch it.
   always_comb begin
      eventos_d = eventos_q;
      if (entrada && eventos_q != 16'hFFFF) eventos_d = eventos_q + 16'd1;
   end

   // Event counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) eventos_q <= 16'd0;
      else        eventos_q <= eventos_d;
   end

   assign eventos = eventos_q;
`endif

endmodule

// File: tb/tb_monitoramento_pressao_histerese.sv
// Self-checking bench for monitoramento_pressao_histerese (default parameters).
module tb_monitoramento_pressao_histerese;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       amostra_valida;
   logic [7:0] pressao;
   logic       reconhece;
   logic [1:0] alerta;
   logic       alarme_travado;
`ifdef MONITORAMENTO_CONTADOR_EVENTOS_EN
   logic [15:0] eventos;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       valida;
      logic [7:0] p;
      logic       rec;
      logic [1:0] exp_alerta;
      logic       exp_trav;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   monitoramento_pressao_histerese dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .amostra_valida (amostra_valida),
      .pressao        (pressao),
      .reconhece      (reconhece),
      .alerta         (alerta),
      .alarme_travado (alarme_travado)
`ifdef MONITORAMENTO_CONTADOR_EVENTOS_EN
      ,
      .eventos        (eventos)
`endif
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] p, input logic r,
                      input logic [1:0] a, input logic t);
      vec_t x;
      x.valida = v; x.p = p; x.rec = r; x.exp_alerta = a; x.exp_trav = t;
      vecs.push_back(x);
   endtask

   // One clock: drive at negedge, sample 1 time unit after the rising edge.
   task automatic step(input logic v, input logic [7:0] p, input logic r);
      @(negedge clk);
      amostra_valida = v;
      pressao        = p;
      reconhece      = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      amostra_valida = 1'b0; pressao = 8'd0; reconhece = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int ev_exp;
      logic [1:0] prev;
      rst_n = 1'b0; amostra_valida = 1'b0; pressao = 8'd0; reconhece = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_alerta", 16'(alerta), 16'd0);
      check("reset_travado", 16'(alarme_travado), 16'd0);

      // Enter ALTO, then an asynchronous reset must clear everything without a clock edge.
      repeat (3) step(1'b1, 8'd160, 1'b0);
      check("pre_rst_alerta", 16'(alerta), 16'd2);
      check("pre_rst_travado", 16'(alarme_travado), 16'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_alerta", 16'(alerta), 16'd0);
      check("async_rst_travado", 16'(alarme_travado), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-streak: two samples, reset, then the streak restarts from zero.
      step(1'b1, 8'd160, 1'b0);
      step(1'b1, 8'd160, 1'b0);
      do_reset();
      step(1'b1, 8'd160, 1'b0);
      check("streak_discard1", 16'(alerta), 16'd0);
      step(1'b1, 8'd160, 1'b0);
      check("streak_discard2", 16'(alerta), 16'd0);
      do_reset();
      #1;

      // Table: valida, pressao, reconhece, expected alerta, expected latch (after the edge).
      add(1, 160, 0, 2'b00, 0); add(1, 160, 0, 2'b00, 0); add(1, 160, 0, 2'b10, 1);
      add(0,   0, 1, 2'b10, 1);
      add(1, 148, 0, 2'b10, 1); add(1, 148, 0, 2'b10, 1); add(1, 148, 0, 2'b10, 1);
      add(1, 144, 0, 2'b10, 1); add(1, 144, 0, 2'b10, 1); add(1, 144, 0, 2'b00, 1);
      add(0,   0, 1, 2'b00, 0);
      add(1, 160, 0, 2'b00, 0); add(1, 160, 0, 2'b00, 0); add(1, 100, 0, 2'b00, 0);
      add(1, 160, 0, 2'b00, 0); add(1, 160, 0, 2'b00, 0); add(1, 160, 0, 2'b10, 1);
      add(1,  20, 0, 2'b10, 1); add(1,  20, 0, 2'b10, 1); add(1,  20, 0, 2'b01, 1);
      add(1,  52, 0, 2'b01, 1); add(1,  52, 0, 2'b01, 1); add(1,  52, 0, 2'b01, 1);
      add(1,  55, 0, 2'b01, 1); add(1,  55, 0, 2'b01, 1); add(1,  55, 0, 2'b00, 1);
      add(0,   0, 1, 2'b00, 0);
      add(1,  30, 0, 2'b00, 0); add(1,  30, 0, 2'b00, 0); add(1,  30, 1, 2'b01, 1);
      add(1, 100, 0, 2'b01, 1); add(1, 100, 0, 2'b01, 1); add(1, 100, 0, 2'b00, 1);
      add(0,   0, 1, 2'b00, 0);
      add(1, 160, 0, 2'b00, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 2'b00, 0);
      add(1, 160, 0, 2'b00, 0); add(0, 0, 0, 2'b00, 0); add(1, 160, 0, 2'b10, 1);
      add(1, 145, 0, 2'b10, 1); add(1, 145, 0, 2'b10, 1); add(1, 145, 0, 2'b10, 1);
      add(1, 100, 0, 2'b10, 1); add(1, 100, 0, 2'b10, 1); add(1, 100, 0, 2'b00, 1);
      add(0,   0, 1, 2'b00, 0);
      add(1, 149, 0, 2'b00, 0); add(1, 149, 0, 2'b00, 0); add(1, 149, 0, 2'b00, 0);
      add(1,  50, 0, 2'b00, 0); add(1,  50, 0, 2'b00, 0); add(1,  50, 0, 2'b00, 0);
      add(1, 150, 0, 2'b00, 0); add(1, 150, 0, 2'b00, 0); add(1, 150, 0, 2'b10, 1);

      ev_exp = 0;
      prev   = 2'b00;
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].valida, vecs[i].p, vecs[i].rec);
         if (vecs[i].exp_alerta != prev && vecs[i].exp_alerta != 2'b00) ev_exp++;
         prev = vecs[i].exp_alerta;
         check($sformatf("vec%0d_alerta", i), 16'(alerta), 16'(vecs[i].exp_alerta));
         check($sformatf("vec%0d_travado", i), 16'(alarme_travado), 16'(vecs[i].exp_trav));
`ifdef MONITORAMENTO_CONTADOR_EVENTOS_EN
         check($sformatf("vec%0d_eventos", i), eventos, 16'(ev_exp));
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
